// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction-fetch stage: PC register, imem handshake, IF/ID register
module pc_fetch_unit #(
   parameter int unsigned         PC_W      = 10,
   parameter int unsigned         INSTR_W   = 32,
   parameter logic [PC_W-1:0]     RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'h00000013
) (
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    pc,
   input  logic [PC_W-1:0]    pc_plus4,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_target,
   input  logic               stall,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [PC_W-1:0]    if_pc,
   output logic [INSTR_W-1:0] if_instr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic                 kill_q, kill_d;
   logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
   logic                 if_valid_q, if_valid_d;
   logic [PC_W-1:0]      if_pc_q, if_pc_d;
   logic [INSTR_W-1:0]   if_instr_q, if_instr_d;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_d       = kill_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      if_valid_d   = stall ? if_valid_q : 1'b0;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;

      unique case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (imem_ready) begin
               state_d = ST_WAIT;
               // a redirect in the accept cycle means the in-flight address is stale
               if (redirect_valid) kill_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (kill_q || redirect_valid) begin
                  kill_d  = 1'b0;
                  state_d = ST_REQ;
               end else if (!stall) begin
                  if_valid_d = 1'b1;
                  if_pc_d    = pc_q;
                  if_instr_d = imem_rdata;
                  pc_d       = pc_plus4;
                  state_d    = ST_REQ;
               end else begin
                  skid_pc_d    = pc_q;
                  skid_instr_d = imem_rdata;
                  state_d      = ST_HOLD;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               state_d = ST_REQ;
            end else if (!stall) begin
               if_valid_d = 1'b1;
               if_pc_d    = skid_pc_q;
               if_instr_d = skid_instr_q;
               pc_d       = pc_plus4;
               state_d    = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // redirect wins over stall and over any delivery decided above
      if (redirect_valid) begin
         pc_d       = {redirect_target[PC_W-1:2], 2'b00};
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         kill_q       <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         if_valid_q   <= 1'b0;
         if_pc_q      <= '0;
         if_instr_q   <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         kill_q       <= kill_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         if_valid_q   <= if_valid_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
      end
   end

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign imem_req  = rst && (state_q == ST_REQ);
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_instr  = if_instr_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the single-issue RISC-V core.
- Owns the program-counter register and drives the current PC to the external PC+4 adder, which returns the next sequential address.
- Selects the next PC from that sequential address or from a branch/jump redirect.
- Runs a request/response handshake with instruction memory and loads the IF/ID pipeline register, honouring decode stalls and redirect flushes.

Parameters:
PC_W, 10, width of PC and instruction-memory byte address
INSTR_W, 32, instruction width
RESET_PC, 10'd0, PC value loaded on reset
NOP_INSTR, 32'h00000013, value placed in if_instr on reset/flush (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-low
pc  out  PC_W  current PC register; feeds the PC+4 adder
pc_plus4  in  PC_W  sequential next PC returned by the adder
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  PC_W  redirect address
stall  in  1  decode stall; IF/ID must hold
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (equals pc)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  INSTR_W  read data
if_valid  out  1  IF/ID holds a live instruction
if_pc  out  PC_W  PC of IF/ID instruction
if_instr  out  INSTR_W  IF/ID instruction

Behaviour:
- Reset (rst==0 at posedge) loads: pc=RESET_PC, state=IDLE, kill=0, skid empty, if_valid=0, if_pc=0, if_instr=NOP_INSTR. While in reset and in IDLE, imem_req=0. Reset overrides every other input, including mid-transaction; responses to requests outstanding at reset are ignored, and kill is cleared so they are not discarded later either.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE: goes to REQ unconditionally on the next cycle.
  - REQ: imem_req=1 and imem_addr=pc. A request is accepted only in a cycle where imem_req&&imem_ready. Before acceptance the address may change. On acceptance, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - If kill=1 or redirect_valid=1: discard the data, clear kill, go to REQ.
    - Otherwise, if stall==0: if_valid<=1, if_pc<=pc, if_instr<=imem_rdata, pc<=pc_plus4, go to REQ.
    - Otherwise (stall==1): capture {pc, rdata} into the skid register and go to HOLD.
  - HOLD: imem_req=0. When stall==0: move skid into IF/ID, pc<=pc_plus4, go to REQ.
- IF/ID register:
  - stall==1: holds all fields.
  - stall==0 with no instruction delivered this cycle: if_valid<=0; if_pc and if_instr hold.
- Redirect (redirect_valid==1) has the highest priority after reset:
  - In every state: pc<=redirect_target with bits [1:0] forced to 00; if_valid<=0 and if_instr<=NOP_INSTR next cycle, even when stall==1.
  - REQ with imem_ready=1: the accepted request is stale, so set kill=1 and go to WAIT.
  - REQ with imem_ready=0: stay in REQ; the new address is presented next cycle.
  - WAIT without rvalid: set kill=1.
  - HOLD: drop the skid register and go to REQ.
  - IDLE: pc is updated and IDLE→REQ proceeds normally.
- Redirect and rvalid in the same cycle: the data is discarded (no kill needed).
- Wrap-around: pc takes pc_plus4 verbatim; 0x3FC→0x000 is legal.
- Latency: imem_rvalid may arrive no earlier than one cycle after acceptance. With zero-wait memory, the first if_valid is high on the 3rd posedge after reset release (IDLE, REQ, WAIT). Throughput is 1 instruction per 2 cycles.
- At most one request is outstanding at a time.

Test Plan:
- Reset release, memory zero-wait returning 0x00500093 at address 0x000: if_valid=1, if_pc=0x000, if_instr=0x00500093 after 3 cycles; next imem_addr=0x004; later if_pc sequence is 0x004, 0x008.
- stall=1 for 4 cycles as rvalid returns the instruction at 0x008: IF/ID holds the 0x004 entry; the 0x008 data sits in the skid register; no imem_req in HOLD. After stall drops: if_pc=0x008 next cycle, then a fetch from 0x00C.
- Redirect to 0x100 in WAIT, with rvalid 2 cycles later carrying 0xDEADBEEF: data discarded; if_valid=0; next imem_addr=0x100; first live if_pc=0x100.
- Redirect to 0x203 in REQ with imem_ready=1: kill set; the next response is dropped; the following request uses address 0x200.
- pc=0x3FC with adder returning 0x000: after the fetch, imem_addr=0x000 and no X values appear.
- rst=0 asserted in WAIT with rvalid the same cycle: all outputs return to their reset values next cycle; the response is ignored; the first post-reset request is issued at RESET_PC.
